// File: rtl/bsg_muxi_gatestack_pipe_pkg.sv
// Shared types and helpers for the gatestack mux pipe.
package bsg_muxi_gatestack_pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_muxi_gatestack_bitwise.sv
// Per-bit els_p-way selector with optional output inversion.
module bsg_muxi_gatestack_bitwise
    import bsg_muxi_gatestack_pipe_pkg::*;
#(
    parameter int width_p = 5,
    parameter int els_p = 2,
    parameter int invert_p = 1,
    localparam int lg_els_lp = safe_clog2(els_p)
) (
    input  logic [els_p*width_p-1:0]     data_i,
    input  logic [width_p*lg_els_lp-1:0] sel_i,
    output logic [width_p-1:0]           data_o
);

    logic [width_p-1:0] w_raw;

    // Unmatched select codes leave the raw bit at 0.
    always_comb begin
        w_raw = '0;
        for (int b = 0; b < width_p; b++) begin
            for (int k = 0; k < els_p; k++) begin
                if (sel_i[b*lg_els_lp +: lg_els_lp] == lg_els_lp'(k)) begin
                    w_raw[b] = data_i[k*width_p + b];
                end
            end
        end
    end

    assign data_o = (invert_p != 0) ? ~w_raw : w_raw;

endmodule

// File: rtl/bsg_muxi_gatestack_pipe.sv
// Per-bit gatestack mux registered behind a 2-entry valid/ready buffer.
module bsg_muxi_gatestack_pipe
    import bsg_muxi_gatestack_pipe_pkg::*;
#(
    parameter int width_p = 5,
    parameter int els_p = 2,
    parameter int invert_p = 1,
    localparam int lg_els_lp = safe_clog2(els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [els_p*width_p-1:0]     data_i,
    input  logic [width_p*lg_els_lp-1:0] sel_i,
    output logic                         ready_and_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i
);

    if (els_p < 2) begin : g_bad_els
        $fatal(1, "bsg_muxi_gatestack_pipe: els_p must be >= 2");
    end

    logic [width_p-1:0] w_result;
    logic               w_enq;
    logic               w_deq;
    occ_e               r_state;
    occ_e               w_state_nxt;
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [width_p-1:0] r_mem [2];

    bsg_muxi_gatestack_bitwise #(
        .width_p (width_p),
        .els_p   (els_p),
        .invert_p(invert_p)
    ) u_mux (
        .data_i(data_i),
        .sel_i (sel_i),
        .data_o(w_result)
    );

    assign ready_and_o = (r_state != OCC_FULL);
    assign v_o         = (r_state != OCC_EMPTY);
    assign data_o      = r_mem[r_rd_ptr];
    assign w_enq       = v_i & ready_and_o;
    assign w_deq       = yumi_i;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            OCC_EMPTY: if (w_enq) w_state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (w_enq & ~w_deq)      w_state_nxt = OCC_FULL;
                else if (w_deq & ~w_enq) w_state_nxt = OCC_EMPTY;
            end
            OCC_FULL: if (w_deq) w_state_nxt = OCC_ONE;
            default: w_state_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= OCC_EMPTY;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enq) begin
                r_mem[r_wr_ptr] <= w_result;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
        end
    end

`ifndef SYNTHESIS
    a_yumi_needs_v: assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
    ) else $error("bsg_muxi_gatestack_pipe: yumi_i while v_o=0");

    // Only non-power-of-two els_p can encode an out-of-range select.
    if ((els_p & (els_p - 1)) != 0) begin : g_oor_warn
        logic w_oor;
        logic r_oor_warned = 1'b0;

        always_comb begin
            w_oor = 1'b0;
            for (int b = 0; b < width_p; b++) begin
                if (int'(sel_i[b*lg_els_lp +: lg_els_lp]) >= els_p) w_oor = 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_i && v_i && w_oor && !r_oor_warned) begin
                $warning("bsg_muxi_gatestack_pipe: select field >= els_p");
                r_oor_warned <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_muxi_gatestack_pipe.sv
// Directed bench for the gatestack mux pipe (els_p=2 inverting, els_p=3 true).
module tb_bsg_muxi_gatestack_pipe;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [9:0]  data_i;
    logic [4:0]  sel_i;
    logic        ready_and_o;
    logic        v_o;
    logic [4:0]  data_o;
    logic        yumi_i;

    logic        v3_i;
    logic [14:0] data3_i;
    logic [9:0]  sel3_i;
    logic        ready3_o;
    logic        v3_o;
    logic [4:0]  data3_o;
    logic        yumi3_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] q[$];

    always #5 clk = ~clk;

    bsg_muxi_gatestack_pipe #(.width_p(5), .els_p(2), .invert_p(1)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .sel_i(sel_i), .ready_and_o(ready_and_o), .v_o(v_o),
        .data_o(data_o), .yumi_i(yumi_i)
    );

    bsg_muxi_gatestack_pipe #(.width_p(5), .els_p(3), .invert_p(0)) u_dut3 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v3_i), .data_i(data3_i),
        .sel_i(sel3_i), .ready_and_o(ready3_o), .v_o(v3_o),
        .data_o(data3_o), .yumi_i(yumi3_i)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] model2(input logic [9:0] d,
                                          input logic [4:0] s);
        logic [4:0] r;
        for (int b = 0; b < 5; b++) r[b] = ~(s[b] ? d[5+b] : d[b]);
        return r;
    endfunction

    initial begin
        int pops;
        int rdy_low;
        reset_i = 1'b1;
        v_i = 1'b0; data_i = '0; sel_i = '0; yumi_i = 1'b0;
        v3_i = 1'b0; data3_i = '0; sel3_i = '0; yumi3_i = 1'b0;
        tick();
        check("rst_v", 32'(v_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ready", 32'(ready_and_o), 32'd1);
        check("rst3_v", 32'(v3_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // single beat, els_p=2 inverting
        v_i = 1'b1; data_i = {5'b10101, 5'b01100}; sel_i = 5'b00111;
        tick();
        v_i = 1'b0;
        check("beat1_v", 32'(v_o), 32'd1);
        check("beat1_data", 32'(data_o), 32'b10010);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        check("beat1_empty", 32'(v_o), 32'd0);

        // els_p=3 true polarity, bit 4 out of range
        v3_i = 1'b1; data3_i = {5'b11111, 5'b00000, 5'b00000};
        sel3_i = {2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        tick();
        v3_i = 1'b0;
        check("oor_v", 32'(v3_o), 32'd1);
        check("oor_data", 32'(data3_o), 32'b01111);
        yumi3_i = 1'b1;
        tick();
        yumi3_i = 1'b0;

        // backpressure: A=11111, B=01001, C=11100
        v_i = 1'b1; data_i = {5'b11111, 5'b00000}; sel_i = 5'b00000;
        tick();
        check("bp_a_ready", 32'(ready_and_o), 32'd1);
        check("bp_a_data", 32'(data_o), 32'b11111);
        data_i = {5'b10110, 5'b00000}; sel_i = 5'b11111;
        tick();
        check("bp_full_ready", 32'(ready_and_o), 32'd0);
        check("bp_full_head", 32'(data_o), 32'b11111);
        data_i = {5'b00000, 5'b00011}; sel_i = 5'b00000;
        tick();
        check("bp_hold_ready", 32'(ready_and_o), 32'd0);
        check("bp_hold_v", 32'(v_o), 32'd1);
        yumi_i = 1'b1;
        tick();
        check("bp_b_data", 32'(data_o), 32'b01001);
        check("bp_b_ready", 32'(ready_and_o), 32'd1);
        tick();
        v_i = 1'b0;
        check("bp_c_data", 32'(data_o), 32'b11100);
        check("bp_c_v", 32'(v_o), 32'd1);
        tick();
        yumi_i = 1'b0;
        check("bp_drained", 32'(v_o), 32'd0);

        // simultaneous enq/deq in ONE: D=00000 then E=10101
        v_i = 1'b1; data_i = {5'b00000, 5'b11111}; sel_i = 5'b00000;
        tick();
        data_i = {5'b01010, 5'b00000}; sel_i = 5'b11111; yumi_i = 1'b1;
        tick();
        v_i = 1'b0;
        check("one_v", 32'(v_o), 32'd1);
        check("one_ready", 32'(ready_and_o), 32'd1);
        check("one_data", 32'(data_o), 32'b10101);
        tick();
        yumi_i = 1'b0;
        check("one_empty", 32'(v_o), 32'd0);

        // streaming
        pops = 0;
        rdy_low = 0;
        for (int i = 0; i < 100; i++) begin
            v_i = 1'b1;
            data_i = 10'($urandom);
            sel_i = 5'($urandom);
            yumi_i = v_o;
            if (!ready_and_o) rdy_low++;
            if (yumi_i) begin
                if (q.size() == 0) check("stream_underflow", 32'd1, 32'd0);
                else check("stream", 32'(data_o), 32'(q.pop_front()));
                pops++;
            end
            if (ready_and_o) q.push_back(model2(data_i, sel_i));
            tick();
        end
        v_i = 1'b0;
        for (int n = 0; n < 4 && v_o; n++) begin
            yumi_i = 1'b1;
            if (q.size() == 0) check("drain_underflow", 32'd1, 32'd0);
            else check("drain", 32'(data_o), 32'(q.pop_front()));
            tick();
        end
        yumi_i = 1'b0;
        check("stream_pops", 32'(pops), 32'd99);
        check("stream_ready_low", 32'(rdy_low), 32'd0);
        check("stream_left", 32'(q.size()), 32'd0);
        check("stream_empty", 32'(v_o), 32'd0);

        // reset while FULL with yumi_i high
        v_i = 1'b1; data_i = {5'b00000, 5'b01010}; sel_i = 5'b00000;
        tick();
        tick();
        check("rf_full", 32'(ready_and_o), 32'd0);
        reset_i = 1'b1; yumi_i = 1'b1;
        tick();
        reset_i = 1'b0; yumi_i = 1'b0; v_i = 1'b0;
        check("rf_v", 32'(v_o), 32'd0);
        check("rf_data", 32'(data_o), 32'd0);
        check("rf_ready", 32'(ready_and_o), 32'd1);
        tick();
        check("rf_stay_empty", 32'(v_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_muxi_gatestack_pipe.md
Name: bsg_muxi_gatestack_pipe

Overview:
- Per-bit N-way selector: each output bit independently picks the same bit position from one of els_p input words, under its own per-bit select field.
- Result is optionally inverted (gatestack mux-inverter semantics).
- Registered behind a 2-entry valid/ready buffer, so it drops into pipelined datapaths (bypass/forwarding muxes in the core and cache) at full throughput with timing isolation.
- Next generation of the fixed 2-way, 5-bit combinational gatestack mux.

Parameters:
- width_p, 5, number of independently selected bits.
- els_p, 2, number of candidate input words; legal range 2..16.
- invert_p, 1, 1 = output is the complement of the selected bit; 0 = true polarity.
- lg_els_lp, `bsg_safe_clog2(els_p)`, derived (localparam); width of each per-bit select field.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  input beat valid.
- data_i  input  els_p*width_p  candidate words; word k occupies bits [k*width_p +: width_p].
- sel_i  input  width_p*lg_els_lp  select field for bit b at [b*lg_els_lp +: lg_els_lp].
- ready_and_o  output  1  block can accept a beat this cycle.
- v_o  output  1  output beat valid.
- data_o  output  width_p  selected, optionally inverted, result.
- yumi_i  input  1  consumer takes the head beat this cycle; legal only when v_o=1.

Behaviour:
- Select function, computed combinationally on the input side:
  - raw[b] = data_i[sel_b*width_p + b] when sel_b < els_p; otherwise raw[b] = 0.
  - result[b] = invert_p ? ~raw[b] : raw[b].
  - Out-of-range select under invert_p=1 therefore yields 1.
- Enqueue occurs when v_i & ready_and_o; the computed result is stored, not the raw inputs.
- Dequeue occurs on yumi_i.
- Storage: 2-entry circular buffer with rd_ptr, wr_ptr (1 bit each) and a full flag. Occupancy states: EMPTY, ONE, FULL.
  - EMPTY: enq -> ONE.
  - ONE: enq & ~deq -> FULL; deq & ~enq -> EMPTY; enq & deq -> ONE (pointers both advance).
  - FULL: deq -> ONE; enq is impossible because ready_and_o=0.
- Handshake outputs:
  - ready_and_o = ~FULL. It is registered state only, with no combinational path from v_i or yumi_i.
  - v_o = ~EMPTY.
  - data_o = entry at rd_ptr.
- Latency: minimum 1 cycle. A beat enqueued at cycle t is visible on data_o with v_o=1 at t+1. No same-cycle bypass.
- Throughput: 1 beat/cycle sustained when yumi_i is asserted each cycle v_o=1.
- Ordering: strict FIFO; beats never dropped or duplicated.
- Reset (sync, reset_i=1 at a clock edge):
  - Pointers = 0 and state = EMPTY.
  - Both storage entries = 0.
  - v_o=0, data_o=0, ready_and_o=1 from the cycle after reset.
  - While reset_i is high, v_i and yumi_i are ignored.
  - Reset mid-stream discards all held beats.
- Assertions (sim only):
  - yumi_i while v_o=0 is an error.
  - sel_b >= els_p warns once when els_p is not a power of two.
  - els_p < 2 is fatal at elaboration.
- Behaviour is undefined for X on sel_i when v_i=1.

Decomposition:
- No new package entries; lg_els_lp is local.
- Natural sub-module: bsg_muxi_gatestack_bitwise, a purely combinational per-bit els_p-way mux with invert_p. Reusable and hardenable separately.
- The pipe wraps it with the 2-entry buffer logic in-module, behaviourally equivalent to bsg_two_fifo with the mux on its input.

Test Plan:
- width_p=5, els_p=2, invert_p=1: reset, then one beat with data_i={w1=5'b10101, w0=5'b01100}, sel_i=5'b00111 (bits 0-2 pick w1, bits 3-4 pick w0) -> next cycle v_o=1, data_o=5'b10010. Before the beat, post-reset v_o=0, data_o=0, ready_and_o=1.
- els_p=3, invert_p=0, one beat with sel field 2'b11 on bit 4 and 2'b10 elsewhere, w2=5'b11111 -> data_o=5'b01111 (out-of-range bit forced 0). Out-of-range warning fires once.
- Backpressure: three beats A, B, C offered back-to-back with yumi_i=0 -> A and B accepted; ready_and_o=0 in the cycle after B; C is held off. Then yumi_i=1 for 3 cycles -> outputs A, B, C in order, and C is enqueued the cycle ready_and_o returns to 1.
- Streaming: 100 random beats with v_i=1 and yumi_i=v_o every cycle -> 1 beat/cycle, ready_and_o stays 1, outputs match the scoreboard model (select+invert) in order.
- Simultaneous enq/deq in ONE state: occupancy remains ONE, data_o advances to the new beat next cycle.
- Reset asserted while FULL with yumi_i=1 -> next cycle v_o=0, data_o=0, ready_and_o=1. No beat emitted.
